// File: rtl/lc4_muldiv.sv
// LC4 multi-cycle multiply / divide / modulo unit.
// Shift-add multiply and restoring divide. Each retires one bit per cycle.
// All outputs are registered.
module lc4_muldiv #(
    parameter int unsigned WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [15:0]          i_insn,
    input  logic [WORD_SIZE-1:0] i_r1data,
    input  logic [WORD_SIZE-1:0] i_r2data,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [WORD_SIZE-1:0] o_result
);

    localparam int unsigned CNT_W = $clog2(WORD_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    // MUL: a = accumulator, b = shifted multiplicand, c = multiplier.
    // DIV: a = partial remainder, b = dividend shifting into the quotient, c = divisor.
    logic [WORD_SIZE-1:0] a_q, a_nxt;
    logic [WORD_SIZE-1:0] b_q, b_nxt;
    logic [WORD_SIZE-1:0] c_q, c_nxt;
    logic                 is_mod, is_mod_nxt;
    logic [WORD_SIZE-1:0] result_nxt;
    logic                 valid_nxt;

    logic                 dec_mul, dec_div, dec_mod;
    logic [WORD_SIZE:0]   rem_sh, rem_diff;

    // Instruction decode for the three supported operations
    always_comb begin
        dec_mul = (i_insn[15:12] == 4'b0001) && (i_insn[5:3] == 3'b001);
        dec_div = (i_insn[15:12] == 4'b0001) && (i_insn[5:3] == 3'b011);
        dec_mod = (i_insn[15:12] == 4'b1010) && (i_insn[5:4] == 2'b11);
    end

    // Restoring-division trial subtract; bit WORD_SIZE of the difference is the borrow
    always_comb begin
        rem_sh   = {a_q, b_q[WORD_SIZE-1]};
        rem_diff = rem_sh - {1'b0, c_q};
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        a_nxt      = a_q;
        b_nxt      = b_q;
        c_nxt      = c_q;
        is_mod_nxt = is_mod;
        result_nxt = o_result;
        valid_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    cnt_nxt = '0;
                    if (dec_mul || dec_div || dec_mod) begin
                        a_nxt      = '0;
                        b_nxt      = i_r1data;
                        c_nxt      = i_r2data;
                        is_mod_nxt = dec_mod;
                        state_nxt  = dec_mul ? MUL : DIV;
                    end else begin
                        result_nxt = '0;
                        valid_nxt  = 1'b1;
                        state_nxt  = DONE;
                    end
                end
            end
            MUL: begin
                if (cnt == CNT_LAST) begin
                    result_nxt = a_q;
                    valid_nxt  = 1'b1;
                    state_nxt  = DONE;
                end else begin
                    if (c_q[0]) begin
                        a_nxt = a_q + b_q;
                    end
                    b_nxt   = b_q << 1;
                    c_nxt   = c_q >> 1;
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DIV: begin
                if (cnt == CNT_LAST) begin
                    if (c_q == '0) begin
                        result_nxt = '0;
                    end else begin
                        result_nxt = is_mod ? a_q : b_q;
                    end
                    valid_nxt = 1'b1;
                    state_nxt = DONE;
                end else begin
                    if (!rem_diff[WORD_SIZE]) begin
                        a_nxt = rem_diff[WORD_SIZE-1:0];
                        b_nxt = {b_q[WORD_SIZE-2:0], 1'b1};
                    end else begin
                        a_nxt = rem_sh[WORD_SIZE-1:0];
                        b_nxt = {b_q[WORD_SIZE-2:0], 1'b0};
                    end
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            is_mod   <= 1'b0;
            o_ready  <= 1'b1;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            c_q      <= c_nxt;
            is_mod   <= is_mod_nxt;
            o_ready  <= (state_nxt == IDLE);
            o_valid  <= valid_nxt;
            o_result <= result_nxt;
        end
    end

endmodule

// File: doc/lc4_muldiv.md
LC4_MULDIV -- requirements
Module: lc4_muldiv

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, the operand/result width in bits, supported range 16..64.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port i_start  input  1  request to begin an operation.
REQ-005 SHALL have port i_insn  input  16  LC4 instruction word selecting the operation.
REQ-006 SHALL have port i_r1data  input  WORD_SIZE  first operand (multiplicand/dividend).
REQ-007 SHALL have port i_r2data  input  WORD_SIZE  second operand (multiplier/divisor).
REQ-008 SHALL have port o_ready  output  1  high when idle and able to accept i_start.
REQ-009 SHALL have port o_valid  output  1  one-cycle pulse marking o_result as newly valid.
REQ-010 SHALL have port o_result  output  WORD_SIZE  result of the last completed operation.

Function
REQ-011 SHALL decode MUL as i_insn[15:12]=0001 with i_insn[5:3]=001, DIV as i_insn[15:12]=0001 with i_insn[5:3]=011, and MOD as i_insn[15:12]=1010 with i_insn[5:4]=11.
REQ-012 SHALL accept a request only on a cycle where i_start=1 and o_ready=1, latching the operands and the decoded operation on that edge.
REQ-013 SHALL ignore i_start while o_ready=0, with no effect on the in-flight operation or its operands.
REQ-014 SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-015 SHALL transition IDLE->MUL on an accepted MUL request, IDLE->DIV on an accepted DIV/MOD request, and IDLE->DONE on an accepted request of any other encoding.
REQ-016 SHALL, in MUL, perform unsigned shift-add, one multiplier bit per cycle for exactly WORD_SIZE cycles, then go to DONE.
REQ-017 SHALL define the MUL result as the low WORD_SIZE bits of the product, discarding overflow.
REQ-018 SHALL, in DIV, perform unsigned restoring division, one quotient bit per cycle for exactly WORD_SIZE cycles, then go to DONE.
REQ-019 SHALL return the quotient for DIV and the remainder for MOD.
REQ-020 SHALL produce a result of 0 for DIV and for MOD when the latched divisor is 0, with iteration count and latency unchanged.
REQ-021 SHALL produce a result of 0 for an unsupported encoding, with latency 1 cycle.
REQ-022 SHALL use an iteration counter of ceil(log2(WORD_SIZE+1)) bits, cleared on accept and terminating on reaching WORD_SIZE, without wrap-around.
REQ-023 SHALL give MUL/DIV/MOD a latency of WORD_SIZE+1 cycles: accept at edge N, o_valid high in the cycle after edge N+WORD_SIZE+1.
REQ-024 SHALL, in DONE, update o_result, pulse o_valid for exactly one cycle, hold o_ready=0, and return to IDLE on the next edge.
REQ-025 SHALL hold o_result stable from DONE until the next DONE, independent of later input changes.
REQ-026 SHALL drive o_ready=1 only in IDLE, so a new request is first acceptable in the cycle after o_valid.
REQ-027 SHALL keep all outputs registered, with no combinational path from any input to any output.

Reset
REQ-028 SHALL, on a rising clk edge with rst_n=0, force state IDLE, o_ready=1, o_valid=0, o_result=0, and clear the counter and datapath registers.
REQ-029 SHALL treat reset asserted mid-operation as an abort: no o_valid is produced for the aborted request, and the first cycle after rst_n returns high is IDLE.
REQ-030 SHALL give reset priority over i_start on the same edge.

Verification
REQ-031 SHALL verify (WORD_SIZE=16): MUL 3*5 accepted at edge 0 -> o_valid a single cycle after edge 17, o_result=15, o_ready=1 the following cycle.
REQ-032 SHALL verify MUL 0xFFFF*0xFFFF -> o_result=0x0001, and MUL 0x0100*0x0100 -> o_result=0x0000.
REQ-033 SHALL verify DIV 100/7 -> o_result=14, MOD 100/7 -> o_result=2, and DIV 0xFFFF/1 -> o_result=0xFFFF.
REQ-034 SHALL verify DIV 9/0 and MOD 9/0 -> o_result=0 at the same latency as a non-zero divisor.
REQ-035 SHALL verify that a second i_start, with different operands, pulsed mid-MUL is ignored -> only the first result appears and o_valid pulses exactly once.
REQ-036 SHALL verify rst_n=0 for one cycle at iteration 8 of DIV -> no o_valid, o_result=0, o_ready=1, and a fresh MUL 2*2 completes with o_result=4.
